// File: rtl/func_sweep_pkg.sv
// Shared types and limits for the truth-table sweeper.
// Holds the FSM state enum and the legal parameter bounds.
package func_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    FIN   = 2'd2
  } state_e;

  localparam int MAX_N      = 6;
  localparam int MAX_SETTLE = 15;

  // settle counter width, enough for MAX_SETTLE-1
  localparam int CNT_W = 4;

endpackage

// File: rtl/func_sweep_bin2gray.sv
// Reflected binary-to-Gray converter, purely combinational.
// Ports: bin_i (N-bit binary in), gray_o (N-bit Gray out).
module bin2gray #(
  parameter int N = 3
) (
  input  logic [N-1:0] bin_i,
  output logic [N-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/func_sweep.sv
// Sweeps every input vector of an external N-input function,
// holds each for SETTLE cycles and captures its truth table.
// Ports: clk, rst (async, active high), start, func_in in;
//   vec_out, busy, done, table_out, ones_cnt out.
module func_sweep
  import func_sweep_pkg::*;
#(
  parameter int N      = 3,
  parameter int SETTLE = 1,
  parameter int GRAY   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              func_in,
  output logic [N-1:0]      vec_out,
  output logic              busy,
  output logic              done,
  output logic [2**N-1:0]   table_out,
  output logic [N:0]        ones_cnt
);

  if (N < 1 || N > MAX_N) begin : g_bad_n
    $error("func_sweep: N out of range");
  end
  if (SETTLE < 1 || SETTLE > MAX_SETTLE) begin : g_bad_settle
    $error("func_sweep: SETTLE out of range");
  end
  if (GRAY != 0 && GRAY != 1) begin : g_bad_gray
    $error("func_sweep: GRAY must be 0 or 1");
  end

  localparam logic [N:0] LAST =
    (N+1)'((2**N) - 1);
  localparam logic [CNT_W-1:0] SET_M1 =
    CNT_W'(SETTLE - 1);

  state_e             state_q, state_d;
  logic [N:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2**N-1:0]    tab_q, tab_d;
  logic [N:0]         ones_q, ones_d;

  logic [N-1:0]       bin_vec;
  logic [N-1:0]       gray_vec;
  logic [N-1:0]       vec;

  // index stays on the last step after a sweep,
  // so vec holds its final value in FIN and IDLE
  assign bin_vec = idx_q[N-1:0];

  bin2gray #(
    .N (N)
  ) u_b2g (
    .bin_i  (bin_vec),
    .gray_o (gray_vec)
  );

  assign vec = (GRAY != 0) ? gray_vec : bin_vec;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tab_d   = tab_q;
    ones_d  = ones_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SWEEP;
          idx_d   = '0;
          cnt_d   = '0;
          tab_d   = '0;
          ones_d  = '0;
        end
      end
      SWEEP: begin
        if (cnt_q == SET_M1) begin
          tab_d[vec] = func_in;
          if (func_in) begin
            ones_d = ones_q + 1'b1;
          end
          cnt_d = '0;
          if (idx_q == LAST) begin
            state_d = FIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tab_q   <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tab_q   <= tab_d;
      ones_q  <= ones_d;
    end
  end

  assign vec_out   = vec;
  assign busy      = (state_q == SWEEP);
  assign done      = (state_q == FIN);
  assign table_out = tab_q;
  assign ones_cnt  = ones_q;

endmodule

// File: tb/tb_func_sweep.sv
// Bench for func_sweep: three configurations against a
// behavioural sweep model plus literal scenario checks.
module tb_func_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  st;
  logic [2:0]  glit;
  logic [2:0]  gbit;
  logic [63:0] tt [3];
  logic        gl_en;

  logic [2:0] vec_a, vec_b;
  logic [0:0] vec_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic [7:0] tab_a, tab_b;
  logic [1:0] tab_c;
  logic [3:0] ones_a, ones_b;
  logic [1:0] ones_c;
  logic       fa, fb, fc;

  assign fa = glit[0] ? gbit[0] : tt[0][vec_a];
  assign fb = glit[1] ? gbit[1] : tt[1][vec_b];
  assign fc = glit[2] ? gbit[2] : tt[2][vec_c];

  func_sweep #(.N(3), .SETTLE(1), .GRAY(0)) u_a (
    .clk(clk), .rst(rst), .start(st[0]), .func_in(fa),
    .vec_out(vec_a), .busy(busy_a), .done(done_a),
    .table_out(tab_a), .ones_cnt(ones_a));

  func_sweep #(.N(3), .SETTLE(3), .GRAY(1)) u_b (
    .clk(clk), .rst(rst), .start(st[1]), .func_in(fb),
    .vec_out(vec_b), .busy(busy_b), .done(done_b),
    .table_out(tab_b), .ones_cnt(ones_b));

  func_sweep #(.N(1), .SETTLE(1), .GRAY(0)) u_c (
    .clk(clk), .rst(rst), .start(st[2]), .func_in(fc),
    .vec_out(vec_c), .busy(busy_c), .done(done_c),
    .table_out(tab_c), .ones_cnt(ones_c));

  logic [5:0]  vv [3];
  logic        bv [3];
  logic        dv [3];
  logic [63:0] tv [3];
  logic [6:0]  ov [3];
  logic        fv [3];

  always_comb begin
    vv[0] = 6'(vec_a);  vv[1] = 6'(vec_b);  vv[2] = 6'(vec_c);
    bv[0] = busy_a;     bv[1] = busy_b;     bv[2] = busy_c;
    dv[0] = done_a;     dv[1] = done_b;     dv[2] = done_c;
    tv[0] = 64'(tab_a); tv[1] = 64'(tab_b); tv[2] = 64'(tab_c);
    ov[0] = 7'(ones_a); ov[1] = 7'(ones_b); ov[2] = 7'(ones_c);
    fv[0] = fa;         fv[1] = fb;         fv[2] = fc;
  end

  function automatic int pn(int j);
    return (j == 2) ? 1 : 3;
  endfunction
  function automatic int ps(int j);
    return (j == 1) ? 3 : 1;
  endfunction
  function automatic int ord(int j, int s);
    return (j == 1) ? (s ^ (s >> 1)) : s;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // behavioural model: phase 0 idle, 1 sweeping, 2 finished;
  // t counts cycles spent in the sweep
  int          ph [3] = '{0, 0, 0};
  int          t  [3] = '{0, 0, 0};
  int          eones [3] = '{0, 0, 0};
  int          evec  [3] = '{0, 0, 0};
  logic [63:0] etab  [3] = '{64'd0, 64'd0, 64'd0};
  int          cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    for (int j = 0; j < 3; j++) begin
      if (rst) begin
        ph[j] = 0; t[j] = 0; eones[j] = 0;
        evec[j] = 0; etab[j] = '0;
      end else if (ph[j] == 0) begin
        if (st[j]) begin
          ph[j] = 1; t[j] = 0; eones[j] = 0;
          evec[j] = 0; etab[j] = '0;
        end
      end else if (ph[j] == 1) begin
        if (t[j] % ps(j) == ps(j) - 1 && fv[j]) begin
          etab[j][ord(j, t[j] / ps(j))] = 1'b1;
          eones[j]++;
        end
        t[j]++;
        if (t[j] == (1 << pn(j)) * ps(j)) ph[j] = 2;
        else evec[j] = ord(j, t[j] / ps(j));
      end else begin
        ph[j] = 0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #3;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("busy[%0d]", j), bv[j], ph[j] == 1);
      chk($sformatf("done[%0d]", j), dv[j], ph[j] == 2);
      chk($sformatf("vec[%0d]", j), vv[j], evec[j]);
      chk($sformatf("table[%0d]", j), tv[j], etab[j]);
      chk($sformatf("ones[%0d]", j), ov[j], eones[j]);
    end
  end

  // glitch func_in on every non-sampling cycle of a vector
  initial forever begin
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      glit[j] = gl_en && ph[j] == 1 &&
                (t[j] % ps(j) != ps(j) - 1) &&
                ($urandom % 2 == 1);
      gbit[j] = 1'($urandom % 2);
    end
  end

  task automatic wait_done(input int j, input int k,
                           output int lat);
    lat = -1;
    for (int i = 0; i < 80; i++) begin
      if (dv[j]) begin
        lat = cyc - k;
        break;
      end
      @(negedge clk);
    end
  endtask

  int k, da, db, dc, lat, nd;
  logic [2:0] q[$];
  logic [31:0] seq;

  initial begin
    rst = 1'b1; st = '0; glit = '0; gbit = '0; gl_en = 1'b0;
    for (int j = 0; j < 3; j++) tt[j] = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_vec", vec_a, 0);
    chk("rst_table", tab_a, 0);
    rst = 1'b0;
    tt[0] = 64'hEA; tt[1] = 64'hEA; tt[2] = 64'h1;
    gl_en = 1'b1;
    @(negedge clk);

    // one sweep on each configuration
    st = 3'b111; k = cyc + 1;
    @(negedge clk);
    st = '0;
    da = -1; db = -1; dc = -1;
    for (int i = 0; i < 60; i++) begin
      if (busy_b && (q.size() == 0 || q[$] != vec_b))
        q.push_back(vec_b);
      if (done_a && da < 0) da = cyc - k;
      if (done_b && db < 0) db = cyc - k;
      if (done_c && dc < 0) dc = cyc - k;
      if (db >= 0) break;
      @(negedge clk);
    end
    chk("lat_a", da, 8);
    chk("lat_b", db, 24);
    chk("lat_c", dc, 2);
    chk("tab_a", tab_a, 8'hEA);
    chk("ones_a", ones_a, 5);
    chk("tab_b", tab_b, 8'hEA);
    chk("ones_b", ones_b, 5);
    chk("tab_c", tab_c, 2'b01);
    chk("ones_c", ones_c, 1);
    seq = '0;
    foreach (q[i]) seq = {seq[27:0], 1'b0, q[i]};
    chk("gray_len", q.size(), 8);
    chk("gray_seq", seq, 32'h01326754);
    @(negedge clk);

    // abort on the fifth busy cycle
    st = 3'b111; k = cyc + 1;
    @(negedge clk);
    st = '0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_vec", vec_a, 0);
    chk("abort_tab", tab_a, 0);
    chk("abort_ones", ones_a, 0);
    chk("abort_busy_b", busy_b, 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_a || done_b || done_c) nd++;
    end
    chk("abort_no_done", nd, 0);
    st = 3'b111; k = cyc + 1;
    @(negedge clk);
    st = '0;
    wait_done(0, k, lat);
    chk("restart_lat", lat, 8);
    chk("restart_tab", tab_a, 8'hEA);
    chk("restart_ones", ones_a, 5);
    wait_done(1, k, lat);
    chk("restart_lat_b", lat, 24);
    repeat (2) @(negedge clk);

    // start held through a whole sweep and its FIN cycle
    st[0] = 1'b1; k = cyc + 1;
    wait_done(0, k, lat);
    chk("held_lat", lat, 8);
    @(negedge clk);
    chk("held_fin_ignored", busy_a, 0);
    @(negedge clk);
    chk("held_reaccept", busy_a, 1);
    st[0] = 1'b0;
    wait_done(0, k + 10, lat);
    chk("held_lat2", lat, 8);
    repeat (2) @(negedge clk);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst = ($urandom % 300 == 0);
      for (int j = 0; j < 3; j++) begin
        st[j] = ($urandom % 4 == 0);
        if ($urandom % 50 == 0) tt[j] = {$urandom, $urandom};
      end
    end
    @(negedge clk);
    rst = 1'b0; st = '0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/func_sweep.md
FUNC_SWEEP -- requirements
Module: func_sweep

Interface
REQ-001 Parameter N, default 3: number of function inputs; legal range 1..6.
REQ-002 Parameter SETTLE, default 1: cycles each vector is held before sampling; legal range 1..15.
REQ-003 Parameter GRAY, default 0: sweep order; 0 = binary ascending, 1 = reflected Gray code.
REQ-004 clk  in  1: single clock; all state changes on rising edge.
REQ-005 rst  in  1: asynchronous, active-high reset.
REQ-006 start  in  1: request a full sweep; sampled only in IDLE.
REQ-007 func_in  in  1: output of the external N-input combinational function under test.
REQ-008 vec_out  out  N: input vector driven to the external function; vec_out[N-1] is the MSB (first-named input).
REQ-009 busy  out  1: high while a sweep is in progress.
REQ-010 done  out  1: one-cycle pulse at sweep completion.
REQ-011 table_out  out  2**N: captured truth table; bit i = func_in sampled while vec_out == i.
REQ-012 ones_cnt  out  N+1: count of true minterms in the current or last sweep.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SWEEP and FIN.
REQ-014 In IDLE, start=1 at a rising edge SHALL move the FSM to SWEEP, clear table_out and ones_cnt, reset the step index to 0 and clear the settle counter.
REQ-015 In SWEEP, vec_out SHALL equal the step index when GRAY=0, or index ^ (index >> 1) when GRAY=1.
REQ-016 Each vector SHALL be held for exactly SETTLE cycles; func_in SHALL be sampled at the edge that ends the SETTLE-th cycle.
REQ-017 A sample SHALL write table_out[vec_out] and increment ones_cnt when func_in=1; all other table bits are unchanged.
REQ-018 After the sample for step index 2**N-1, the FSM SHALL go to FIN; otherwise the index increments and the settle counter restarts.
REQ-019 busy SHALL be 1 exactly in SWEEP: 2**N*SETTLE cycles, starting at the edge that accepts start.
REQ-020 FIN SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-021 start SHALL be ignored in SWEEP and FIN; no queuing; start in the FIN cycle has no effect.
REQ-022 table_out and ones_cnt SHALL hold their final values in IDLE until the next accepted start.
REQ-023 vec_out SHALL hold its last value in FIN and IDLE.
REQ-024 The step index SHALL be N+1 bits wide so the terminal compare cannot wrap; ones_cnt SHALL never exceed 2**N.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, with vec_out=0, busy=0, done=0, table_out=0, ones_cnt=0 and both counters at 0.
REQ-026 rst asserted mid-sweep SHALL abort the sweep with no done pulse; a new start after reset release SHALL begin from index 0.

Structure
REQ-027 Package func_sweep_pkg SHALL hold the state enumeration and the maximum legal N and SETTLE constants.
REQ-028 Binary-to-Gray conversion SHALL be a separate combinational sub-module bin2gray, parameterised by width N.
REQ-029 Illegal parameter values SHALL fail elaboration.

Verification
REQ-030 N=3, SETTLE=1, GRAY=0, func_in=(a&b)|c: start at edge k -> busy for 8 cycles, done at k+8, table_out=8'hEA, ones_cnt=5.
REQ-031 N=3, GRAY=1: vec_out sequence is 0,1,3,2,6,7,5,4; the same function still gives table_out=8'hEA.
REQ-032 N=3, SETTLE=3: each vector is held 3 cycles, done at k+24; func_in glitching in the first 2 cycles of each vector does not affect table_out.
REQ-033 rst pulsed at the 5th busy cycle -> all outputs 0 at once, no done; a restart completes normally with the correct table.
REQ-034 start held high for the whole sweep -> exactly one sweep with one done, a second sweep is accepted in the IDLE cycle after FIN, and start in the FIN cycle is ignored.
REQ-035 N=1, func_in=~vec_out[0] -> table_out=2'b01, ones_cnt=1, done 2 cycles after start acceptance.
